sobel_thres_display: RTL and testbench

- Reads the live Sobel threshold register and shows it in decimal on the board's 4-digit multiplexed 7-segment display.
- A sequential shift-add-3 (double-dabble) converter turns the 8-bit value into 3 BCD digits; a scan counter time-multiplexes the digits.
- Runs entirely in the clk_pixel_division domain, the same domain in which threshold is updated, so no CDC logic is needed.

---
 rtl/sobel_disp_pkg.sv | 51 +++++
 rtl/sobel_thres_display_if.sv | 29 ++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/sobel_thres_display.sv | 124 ++++++++++++
 tb/tb_sobel_thres_display.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_disp_pkg.sv
// rtl/sobel_disp_pkg.sv - shared constants, segment codes and converter state encoding
package sobel_disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 12;

  // Active-high segment codes, bit order {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_T     = 8'h78;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    LATCH = 2'd2
  } conv_state_e;

  // Decimal digit to active-high segment pattern; non-decimal codes go blank.
  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: a nibble of 5 or more would exceed 9 after the shift.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/sobel_thres_display_if.sv
// rtl/sobel_thres_display_if.sv - threshold input and display/debug outputs bundle
interface sobel_thres_display_if;
  import sobel_disp_pkg::*;

  logic [7:0]       threshold;
  logic [7:0]       seg;
  logic [3:0]       an;
  logic [BCD_W-1:0] bcd_value;
  logic             conv_busy;

  // Side that supplies the threshold and watches the display.
  modport master (
    output threshold,
    input  seg,
    input  an,
    input  bcd_value,
    input  conv_busy
  );

  // The display block itself.
  modport slave (
    input  threshold,
    output seg,
    output an,
    output bcd_value,
    output conv_busy
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 converter, 8-bit binary to 3 BCD digits
module bin2bcd_seq
  import sobel_disp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       bin_i,
  output logic             accept_o,
  output logic             done_o,
  output logic [7:0]       snap_o,
  output logic [BCD_W-1:0] bcd_value_o,
  output logic             conv_busy_o
);

  conv_state_e      state_q, state_d;
  logic [19:0]      sr_q, sr_d;
  logic [19:0]      sr_adj;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       snap_q, snap_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  // Add-3 correction on the three BCD nibbles before each shift.
  assign sr_adj = {add3_nibble(sr_q[19:16]), add3_nibble(sr_q[15:12]),
                   add3_nibble(sr_q[11:8]), sr_q[7:0]};

  // State, shift register, bit counter, snapshot and latched result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
    end
  end

  // Next-state and datapath control: IDLE waits for a request, CONV runs 8 shifts, LATCH publishes.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    bcd_d    = bcd_q;
    accept_o = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          snap_d   = bin_i;
          sr_d     = {12'h000, bin_i};
          cnt_d    = 3'd0;
          accept_o = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        sr_d  = {sr_adj[18:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bcd_d   = sr_q[19:8];
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign snap_o      = snap_q;
  assign bcd_value_o = bcd_q;
  assign conv_busy_o = (state_q == CONV);

endmodule

// File: rtl/sobel_thres_display.sv
// rtl/sobel_thres_display.sv - Sobel threshold on a 4-digit muxed 7-seg display; option THRESH_SEG_LZB_EN blanks leading zeros
module sobel_thres_display
  import sobel_disp_pkg::*;
#(
  parameter logic [23:0] SCAN_TICKS     = 24'd25_000,
  parameter logic        SEG_ACTIVE_LOW = 1'b1,
  parameter logic        AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk_pixel_division,
  input  logic                 rst_n,
  sobel_thres_display_if.slave bus
);

  logic [7:0]       thr_q;
  logic [7:0]       thr_last_q;
  logic             pending_q;
  logic [23:0]      scan_cnt_q, scan_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_raw;
  logic [3:0]       an_onehot;
  logic             conv_start;
  logic             conv_accept;
  logic             conv_done;
  logic [7:0]       conv_src;
  logic [7:0]       conv_snap;
  logic [BCD_W-1:0] bcd_value;
  logic             conv_busy;
  logic [3:0]       d_ones, d_tens, d_hund;
  logic             blank_tens, blank_hund;

  // The post-reset conversion starts before thr_q has captured anything, so it
  // takes the live input; every later conversion uses the registered copy.
  assign conv_start = pending_q | (thr_q != thr_last_q);
  assign conv_src   = pending_q ? bus.threshold : thr_q;

  bin2bcd_seq u_bin2bcd (
    .clk_i       (clk_pixel_division),
    .rst_ni      (rst_n),
    .start_i     (conv_start),
    .bin_i       (conv_src),
    .accept_o    (conv_accept),
    .done_o      (conv_done),
    .snap_o      (conv_snap),
    .bcd_value_o (bcd_value),
    .conv_busy_o (conv_busy)
  );

  // Input register, last-converted value and the one-shot post-reset request.
  always_ff @(posedge clk_pixel_division or negedge rst_n) begin
    if (!rst_n) begin
      thr_q      <= '0;
      thr_last_q <= '0;
      pending_q  <= 1'b1;
    end else begin
      thr_q <= bus.threshold;
      if (conv_accept) begin
        pending_q <= 1'b0;
      end
      if (conv_done) begin
        thr_last_q <= conv_snap;
      end
    end
  end

  // Scan timer: each digit slot lasts SCAN_TICKS clocks.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 24'd1;
    digit_idx_d = digit_idx_q;
    if (scan_cnt_q == (SCAN_TICKS - 24'd1)) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end
  end

  assign d_ones = bcd_value[3:0];
  assign d_tens = bcd_value[7:4];
  assign d_hund = bcd_value[11:8];

`ifdef THRESH_SEG_LZB_EN
  assign blank_hund = (d_hund == 4'd0);
  assign blank_tens = (d_hund == 4'd0) && (d_tens == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  // Segment pattern for the slot about to be shown, driven from the latched value only.
  always_comb begin
    seg_raw = SEG_BLANK;
    case (digit_idx_d)
      2'd0:    seg_raw = seg_digit(d_ones);
      2'd1:    seg_raw = blank_tens ? SEG_BLANK : seg_digit(d_tens);
      2'd2:    seg_raw = blank_hund ? SEG_BLANK : seg_digit(d_hund);
      default: seg_raw = SEG_T;
    endcase
  end

  assign an_onehot = 4'b0001 << digit_idx_d;
  assign seg_d     = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign an_d      = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;

  // Scan state and display outputs; seg and an move on the same edge.
  always_ff @(posedge clk_pixel_division or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      seg_q       <= {8{SEG_ACTIVE_LOW}};
      an_q        <= {4{AN_ACTIVE_LOW}};
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.bcd_value = bcd_value;
  assign bus.conv_busy = conv_busy;

endmodule

// File: tb/tb_sobel_thres_display.sv
// tb/tb_sobel_thres_display.sv - self-checking bench for sobel_thres_display
module tb_sobel_thres_display;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   applied [256];

`ifdef THRESH_SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  sobel_thres_display_if dif ();

  sobel_thres_display #(
    .SCAN_TICKS     (24'd4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_pixel_division (clk),
    .rst_n              (rst_n),
    .bus                (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected active-low segment pattern for display slot (0=ones .. 3=letter t).
  function automatic logic [7:0] exp_seg(input int slot, input int v);
    int h, t, o;
    logic [7:0] code;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (slot)
      0:       code = seg_tab[o];
      1:       code = (LZB && h == 0 && t == 0) ? 8'h00 : seg_tab[t];
      2:       code = (LZB && h == 0) ? 8'h00 : seg_tab[h];
      default: code = 8'h78;
    endcase
    return ~code;
  endfunction

  function automatic int an2slot(input logic [3:0] a);
    case (a)
      4'hE:    return 0;
      4'hD:    return 1;
      4'hB:    return 2;
      4'h7:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] next_an(input logic [3:0] a);
    case (a)
      4'hE:    return 4'hD;
      4'hD:    return 4'hB;
      4'hB:    return 4'h7;
      default: return 4'hE;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_thr(input int v);
    #1;
    dif.threshold = 8'(v);
    applied[v] = 1'b1;
  endtask

  // Every newly latched value must be the decimal form of some applied threshold.
  logic [11:0] mon_prev = 12'h000;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mon_prev = dif.bcd_value;
    end else if (dif.bcd_value !== mon_prev) begin
      bit found;
      found = 1'b0;
      for (int v = 0; v < 256; v++) begin
        if (applied[v] && to_bcd(v) == dif.bcd_value) found = 1'b1;
      end
      chk("latch_known_value", {31'd0, found}, 32'd1);
      mon_prev = dif.bcd_value;
    end
  end

  initial begin
    int busy_cnt;
    int slot;
    int run;
    bit first;
    logic [3:0] prev_an;
    logic [3:0] seen;
    logic [11:0] prev_bcd;
    logic [11:0] chg_q[$];
    int v;

    rst_n = 1'b1;
    dif.threshold = 8'd128;
    applied[128] = 1'b1;
    #3 rst_n = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_seg", dif.seg, 8'hFF);
    chk("rst_an", dif.an, 4'hF);
    chk("rst_bcd", dif.bcd_value, 12'h000);
    chk("rst_busy", dif.conv_busy, 1'b0);

    // First conversion after release: result exactly 10 edges later.
    rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (dif.conv_busy) busy_cnt++;
      if (k == 9)  chk("boot_bcd_before", dif.bcd_value, 12'h000);
      if (k == 10) chk("boot_bcd_at10", dif.bcd_value, 12'h128);
    end
    chk("boot_busy_cycles", busy_cnt, 8);
    repeat (5) tick();

    // Change while idle: result exactly 11 edges later.
    set_thr(255);
    busy_cnt = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (dif.conv_busy) busy_cnt++;
      if (k == 10) chk("idle_bcd_at10", dif.bcd_value, 12'h128);
      if (k == 11) chk("idle_bcd_at11", dif.bcd_value, 12'h255);
    end
    chk("idle_busy_cycles", busy_cnt, 8);

    // Scan order, slot length and segment content for 255.
    tick();
    prev_an = dif.an;
    run = 1;
    first = 1'b1;
    repeat (40) begin
      tick();
      slot = an2slot(dif.an);
      chk("scan_an_onehot", {31'd0, slot >= 0}, 32'd1);
      if (slot >= 0) chk("scan_seg", dif.seg, exp_seg(slot, 255));
      if (dif.an == prev_an) begin
        run++;
      end else begin
        if (!first) chk("scan_run_len", run, 4);
        chk("scan_order", dif.an, next_an(prev_an));
        first = 1'b0;
        run = 1;
        prev_an = dif.an;
      end
    end

    // Change mid-conversion: 128 -> 0, then 7 four cycles into that conversion.
    set_thr(128);
    repeat (30) tick();
    chk("pre_mid_bcd", dif.bcd_value, 12'h128);
    prev_bcd = dif.bcd_value;
    chg_q.delete();
    set_thr(0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (dif.bcd_value !== prev_bcd) begin chg_q.push_back(dif.bcd_value); prev_bcd = dif.bcd_value; end
    end
    set_thr(7);
    repeat (30) begin
      tick();
      if (dif.bcd_value !== prev_bcd) begin chg_q.push_back(dif.bcd_value); prev_bcd = dif.bcd_value; end
    end
    chk("mid_chg_count", chg_q.size(), 2);
    if (chg_q.size() == 2) begin
      chk("mid_first", chg_q[0], 12'h000);
      chk("mid_second", chg_q[1], 12'h007);
    end

    // Display of 7 (blanking depends on build option).
    seen = 4'h0;
    repeat (20) begin
      tick();
      slot = an2slot(dif.an);
      chk("disp7_an_onehot", {31'd0, slot >= 0}, 32'd1);
      if (slot >= 0) begin
        chk("disp7_seg", dif.seg, exp_seg(slot, 7));
        seen[slot] = 1'b1;
      end
    end
    chk("disp7_all_slots", seen, 4'hF);

    // Reset asserted in the middle of a conversion.
    set_thr(200);
    repeat (5) tick();
    chk("midrst_busy_pre", dif.conv_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", dif.seg, 8'hFF);
    chk("midrst_an", dif.an, 4'hF);
    chk("midrst_bcd", dif.bcd_value, 12'h000);
    chk("midrst_busy", dif.conv_busy, 1'b0);
    dif.threshold = 8'd99;
    applied[99] = 1'b1;
    tick();
    chk("midrst_hold_bcd", dif.bcd_value, 12'h000);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 9)  chk("midrst_bcd_before", dif.bcd_value, 12'h000);
      if (k == 10) chk("midrst_bcd_after", dif.bcd_value, 12'h099);
    end

    // Random thresholds, some changed again while a conversion may be running.
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 255));
      set_thr(v);
      repeat ($urandom_range(0, 12)) tick();
      if ($urandom_range(0, 1) == 1) begin
        v = int'($urandom_range(0, 255));
        set_thr(v);
      end
      repeat (30) tick();
      chk("rand_bcd", dif.bcd_value, to_bcd(v));
      chk("rand_idle", dif.conv_busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
